edge_frame_streamer: RTL and testbench

- Reader side of the processed-image buffer: reads the thresholded edge frame (8-bit pixels, raster order) out of the output memory after preprocessing finishes.
- Emits the frame as a valid/ready pixel stream with start-of-frame, end-of-line and end-of-frame markers, for the downstream detector or the host link.
- Absorbs downstream backpressure against a 1-cycle-latency synchronous memory read port without losing or duplicating pixels.

---
 rtl/face_pkg.sv | 26 ++
 rtl/stream_fifo2.sv | 44 ++++
 rtl/edge_frame_streamer.sv | 149 ++++++++++++++
 tb/tb_edge_frame_streamer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/face_pkg.sv
// rtl/face_pkg.sv - shared types and defaults for the edge frame streamer
//   IMG_WIDTH_DEF / IMG_HEIGHT_DEF : default frame geometry
//   PIX_W                          : pixel width
//   state_t                        : controller states
//   beat_t                         : one stream beat {data, sof, eol, eof}
package face_pkg;

    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 64;
    localparam int PIX_W          = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } beat_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry synchronous FIFO of stream beats
//   clk, reset_n      : clock, asynchronous active-low reset
//   push, push_beat   : write one beat (caller never pushes when full)
//   pop               : drop the head beat (caller never pops when empty)
//   head              : current head beat
//   count             : occupancy 0..2
module stream_fifo2
    import face_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  beat_t      push_beat,
    input  logic       pop,
    output beat_t      head,
    output logic [1:0] count
);

    beat_t slot [2];
    logic  wr_ptr;
    logic  rd_ptr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (push) begin
                slot[wr_ptr] <= push_beat;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = slot[rd_ptr];

endmodule

// File: rtl/edge_frame_streamer.sv
// rtl/edge_frame_streamer.sv - streams a thresholded edge frame out of memory
//   clk, reset_n                          : clock, asynchronous active-low reset
//   start / busy / done                   : frame control and status
//   mem_rd_en, mem_rd_addr, mem_rd_data   : 1-cycle-latency synchronous read port
//   m_valid, m_ready, m_data              : pixel stream handshake and data
//   m_sof, m_eol, m_eof                   : frame markers travelling with each beat
//   BORDER_MASK_EN (macro)                : when defined, border pixels are forced to 0
module edge_frame_streamer
    import face_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int ADDR_W     = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [PIX_W-1:0]  mem_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0]     COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0]     ROW_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;

    // Markers of the read currently in flight; they join the data when it lands.
    logic              inflight;
    logic              pend_sof;
    logic              pend_eol;
    logic              pend_eof;

    logic [1:0]        fifo_count;
    beat_t             fifo_head;
    beat_t             push_beat;
    logic [PIX_W-1:0]  push_data;
    logic              pop;
    logic              issue;

    assign m_valid = (fifo_count != 2'd0);
    assign pop     = m_valid && m_ready;

    // Only issue a read when a FIFO slot is guaranteed for it on landing:
    // occupancy + in-flight - pop < 2, rearranged to stay unsigned.
    assign issue = (state == ST_STREAM) &&
                   (({1'b0, fifo_count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_STREAM;
            ST_STREAM: if (issue && (addr == ADDR_LAST)) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (!inflight && (fifo_count == 2'd0)) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            addr     <= '0;
            col      <= '0;
            row      <= '0;
            inflight <= 1'b0;
            pend_sof <= 1'b0;
            pend_eol <= 1'b0;
            pend_eof <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= issue;
            if ((state == ST_IDLE) && start) begin
                addr <= '0;
                col  <= '0;
                row  <= '0;
            end else if (issue) begin
                pend_sof <= (row == '0) && (col == '0);
                pend_eol <= (col == COL_LAST);
                pend_eof <= (addr == ADDR_LAST);
                addr     <= addr + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    // Row saturates on the last line so it never leaves the frame.
                    if (row != ROW_LAST) row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

`ifdef BORDER_MASK_EN
    // Border pixels never went through the preprocessing kernel; zero them.
    logic pend_border;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_border <= 1'b0;
        end else if (issue) begin
            pend_border <= (row == '0) || (row == ROW_LAST) ||
                           (col == '0) || (col == COL_LAST);
        end
    end

    assign push_data = pend_border ? '0 : mem_rd_data;
`else
    assign push_data = mem_rd_data;
`endif

    assign push_beat = '{data: push_data, sof: pend_sof, eol: pend_eol, eof: pend_eof};

    stream_fifo2 u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (inflight),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Stale head contents are masked so the stream reads all-zero when idle.
    assign m_data      = m_valid ? fifo_head.data : '0;
    assign m_sof       = m_valid && fifo_head.sof;
    assign m_eol       = m_valid && fifo_head.eol;
    assign m_eof       = m_valid && fifo_head.eof;

    assign busy        = (state == ST_STREAM) || (state == ST_DRAIN);
    assign done        = (state == ST_DONE);
    assign mem_rd_en   = issue;
    assign mem_rd_addr = issue ? addr : '0;

endmodule

// File: tb/tb_edge_frame_streamer.sv
// tb/tb_edge_frame_streamer.sv - scoreboard bench for edge_frame_streamer (4x4 and 64x64)
module tb_edge_frame_streamer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic        a_start, a_busy, a_done, a_rd_en, a_ready, a_valid, a_sof, a_eol, a_eof;
    logic [11:0] a_addr;
    logic [7:0]  a_rd_data, a_data;

    logic        b_start, b_busy, b_done, b_rd_en, b_ready, b_valid, b_sof, b_eol, b_eof;
    logic [11:0] b_addr;
    logic [7:0]  b_rd_data, b_data;

    edge_frame_streamer #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ADDR_W(12)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd_en), .mem_rd_addr(a_addr), .mem_rd_data(a_rd_data),
        .m_valid(a_valid), .m_ready(a_ready), .m_data(a_data),
        .m_sof(a_sof), .m_eol(a_eol), .m_eof(a_eof)
    );

    edge_frame_streamer dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_rd_addr(b_addr), .mem_rd_data(b_rd_data),
        .m_valid(b_valid), .m_ready(b_ready), .m_data(b_data),
        .m_sof(b_sof), .m_eol(b_eol), .m_eof(b_eof)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [10:0] qa[$];
    logic [10:0] qb[$];

    bit a_ff_mode = 0;
    bit a_rand    = 0;
    bit a_lat_chk = 1;
    bit a_first   = 1;
    bit b_first   = 1;
    bit a_pstall  = 0;
    logic [10:0] a_pbeat;
    int a_start_cyc = 0, a_beats = 0, a_issued = 0, a_dones = 0;
    int b_start_cyc = 0, b_beats = 0, b_eols = 0, b_dones = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [10:0] exp_beat(input int w, input int h, input int i, input bit ff);
        int col;
        logic [7:0] d;
        col = i % w;
        d   = ff ? 8'hFF : 8'(i);
`ifdef BORDER_MASK_EN
        begin
            int row;
            row = i / w;
            if (row == 0 || row == h - 1 || col == 0 || col == w - 1) d = 8'h00;
        end
`endif
        return {d, i == 0, col == w - 1, i == w * h - 1};
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (a_rd_en) a_rd_data <= a_ff_mode ? 8'hFF : a_addr[7:0];
    always @(posedge clk) if (b_rd_en) b_rd_data <= b_addr[7:0];

    initial begin
        a_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_ready = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!reset_n) begin
            a_pstall = 0;
        end else begin
            if (a_pstall) begin
                check("a_hold_valid", 32'(a_valid), 32'd1);
                check("a_hold_beat", 32'({a_data, a_sof, a_eol, a_eof}), 32'(a_pbeat));
            end
            if (a_valid && !a_first) begin
                a_first = 1;
                check("a_first_lat", cyc - a_start_cyc, 32'd2);
            end
            if (a_rd_en) a_issued++;
            if (a_valid && a_ready) begin
                if (qa.size() == 0) check("a_extra_beat", 32'd1, 32'd0);
                else check("a_beat", 32'({a_data, a_sof, a_eol, a_eof}), 32'(qa.pop_front()));
                a_beats++;
            end
            check("a_outstanding", 32'((a_issued - a_beats) <= 2), 32'd1);
            if (a_done) begin
                a_dones++;
                if (a_lat_chk) check("a_done_lat", cyc - a_start_cyc, 32'd19);
            end
            a_pstall = a_valid && !a_ready;
            a_pbeat  = {a_data, a_sof, a_eol, a_eof};
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (b_valid && !b_first) begin
                b_first = 1;
                check("b_first_lat", cyc - b_start_cyc, 32'd2);
            end
            if (b_valid && b_ready) begin
                if (qb.size() == 0) check("b_extra_beat", 32'd1, 32'd0);
                else check("b_beat", 32'({b_data, b_sof, b_eol, b_eof}), 32'(qb.pop_front()));
                b_beats++;
                if (b_eol) b_eols++;
            end
            if (b_done) begin
                b_dones++;
                check("b_done_lat", cyc - b_start_cyc, 32'd4099);
            end
        end
    end

    task automatic start_a();
        @(posedge clk);
        #1;
        a_start     = 1'b1;
        a_start_cyc = cyc + 1;
        a_first     = 0;
        a_issued    = 0;
        a_beats     = 0;
        for (int i = 0; i < 16; i++) qa.push_back(exp_beat(4, 4, i, a_ff_mode));
        @(posedge clk);
        #1;
        a_start = 1'b0;
        check("a_busy_rise", 32'(a_busy), 32'd1);
    endtask

    task automatic wait_done_a(input int budget);
        int d0;
        int n;
        d0 = a_dones;
        n  = 0;
        while (a_dones == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("a_done_seen", 32'(a_dones != d0), 32'd1);
        repeat (3) @(negedge clk);
        check("a_single_done", a_dones, d0 + 1);
        check("a_queue_empty", qa.size(), 32'd0);
        check("a_busy_fall", 32'(a_busy), 32'd0);
    endtask

    task automatic wait_beats_a(input int nb);
        int n;
        n = 0;
        while (a_beats < nb && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("a_beats_reached", 32'(a_beats >= nb), 32'd1);
    endtask

    initial begin
        int d0;
        int n;
        reset_n = 1'b0;
        a_start = 1'b0;
        b_start = 1'b0;
        b_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        check("rst_done", 32'(a_done), 32'd0);
        check("rst_rd_en", 32'(a_rd_en), 32'd0);
        check("rst_beat", 32'({a_data, a_sof, a_eol, a_eof}), 32'd0);
        check("rst_b_valid", 32'(b_valid), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);

        // ramp frame, ready held high
        a_lat_chk = 1;
        start_a();
        wait_done_a(100);

        // ramp frame, random backpressure
        a_rand    = 1;
        a_lat_chk = 0;
        start_a();
        wait_done_a(300);
        a_rand    = 0;
        a_lat_chk = 1;

        // start pulsed mid-frame is ignored
        start_a();
        wait_beats_a(5);
        @(posedge clk);
        #1 a_start = 1'b1;
        @(posedge clk);
        #1 a_start = 1'b0;
        wait_done_a(100);

        // reset mid-frame aborts immediately
        start_a();
        wait_beats_a(8);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_valid", 32'(a_valid), 32'd0);
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_rd_en", 32'(a_rd_en), 32'd0);
        check("abort_done", 32'(a_done), 32'd0);
        d0 = a_dones;
        qa.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_no_done", a_dones, d0);
        start_a();
        wait_done_a(100);

        // all-0xFF memory (border handling depends on build)
        a_ff_mode = 1;
        start_a();
        wait_done_a(100);
        a_ff_mode = 0;

        // full default-size frame
        @(posedge clk);
        #1;
        b_start     = 1'b1;
        b_start_cyc = cyc + 1;
        b_first     = 0;
        for (int i = 0; i < 4096; i++) qb.push_back(exp_beat(64, 64, i, 1'b0));
        @(posedge clk);
        #1 b_start = 1'b0;
        d0 = b_dones;
        n  = 0;
        while (b_dones == d0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("b_done_seen", 32'(b_dones != d0), 32'd1);
        check("b_beats", b_beats, 32'd4096);
        check("b_eol_count", b_eols, 32'd64);
        check("b_queue_empty", qb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
